// File: rtl/seg7_mux_driver.sv
// Multiplexed 7-segment driver: prescaled digit scan, shadowed frame-synced
// loads, polarity control. Optional leading-zero blanking via SEG7_LZB_EN.
module seg7_mux_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEAD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank,
  input  logic                    seg_pol,
  input  logic                    com_pol,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   com_out,
  output logic [NUM_DIGITS-1:0]   com_oe,
  output logic                    frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         disp_val;
  logic [VW-1:0]         shd_val;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] shd_dp;
  logic                  pending;

  logic                  slot_end;
  logic                  last_dig;
  logic                  boundary;
  logic                  show;
  logic                  com_act;
  logic                  dig_off;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic [NUM_DIGITS-1:0] com_vec;
  logic [7:0]            lit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
    endcase
  endfunction

  assign slot_end = ena && (cnt == CW'(SCAN_DIV - 1));
  assign last_dig = (idx == IW'(NUM_DIGITS - 1));
  assign boundary = slot_end && last_dig;
  assign show     = ena && !blank;
  assign com_act  = (cnt >= CW'(DEAD_CYC));

  always_comb begin
    nib     = '0;
    dp_bit  = 1'b0;
    com_vec = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib        = disp_val[4*i +: 4];
        dp_bit     = disp_dp[i];
        com_vec[i] = com_act;
      end
    end
  end

`ifdef SEG7_LZB_EN
  // A digit goes dark only while every digit above it is also a bare zero.
  logic [NUM_DIGITS-1:0] lz;

  always_comb begin
    logic run;
    run = 1'b1;
    lz  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run   = run && (disp_val[4*i +: 4] == 4'h0) && !disp_dp[i];
      lz[i] = run;
    end
  end

  assign dig_off = lz[idx];
`else
  assign dig_off = 1'b0;
`endif

  assign lit = dig_off ? 8'h00 : {dp_bit, hex7(nib)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (ena) begin
      if (slot_end) begin
        cnt <= '0;
        idx <= last_dig ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // A load coinciding with the boundary lands in the shadow for next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_val  <= '0;
      shd_dp   <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      pending  <= 1'b0;
    end else begin
      if (boundary && pending) begin
        disp_val <= shd_val;
        disp_dp  <= shd_dp;
      end
      if (load) begin
        shd_val <= value;
        shd_dp  <= dp_mask;
        pending <= 1'b1;
      end else if (boundary && pending) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= '0;
      com_out    <= '0;
      com_oe     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      com_oe     <= {NUM_DIGITS{ena}};
      if (show) begin
        seg_out <= lit ^ {8{~seg_pol}};
        com_out <= com_vec ^ {NUM_DIGITS{~com_pol}};
      end else begin
        seg_out <= {8{~seg_pol}};
        com_out <= {NUM_DIGITS{~com_pol}};
      end
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Randomized scoreboard bench for seg7_mux_driver (2 digits, div 4, dead 1).
// Honours SEG7_LZB_EN in its reference model.
module tb_seg7_mux_driver;

  localparam int ND = 2;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int FRAME = SD * ND;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          load;
  logic [7:0]    value;
  logic [ND-1:0] dp_mask;
  logic          blank;
  logic          seg_pol;
  logic          com_pol;
  logic [7:0]    seg_out;
  logic [ND-1:0] com_out;
  logic [ND-1:0] com_oe;
  logic          frame_done;

  typedef struct packed {
    logic [7:0]    seg;
    logic [ND-1:0] com;
    logic [ND-1:0] oe;
    logic          fd;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int   pos;
  int   shd_v, shd_dp, disp_v, disp_dp;
  bit   pend;
  int   tbl[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                    'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  seg7_mux_driver #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD),
    .DEAD_CYC  (DC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load      (load),
    .value     (value),
    .dp_mask   (dp_mask),
    .blank     (blank),
    .seg_pol   (seg_pol),
    .com_pol   (com_pol),
    .seg_out   (seg_out),
    .com_out   (com_out),
    .com_oe    (com_oe),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic bit digit_dark(input int d);
    bit dark;
    dark = 1'b0;
`ifdef SEG7_LZB_EN
    if (d > 0) begin
      dark = 1'b1;
      for (int j = d; j < ND; j++)
        if (((disp_v >> (4 * j)) & 15) != 0 || ((disp_dp >> j) & 1) != 0)
          dark = 1'b0;
    end
`endif
    return dark;
  endfunction

  // Predict outputs after the coming edge, then advance the model.
  task automatic predict();
    exp_t e;
    int   cnt, d, segs, com;
    bit   bnd;
    if (!rst_n) begin
      e = '0;
      pos = 0; shd_v = 0; shd_dp = 0; disp_v = 0; disp_dp = 0; pend = 0;
    end else begin
      cnt = pos % SD;
      d   = (pos / SD) % ND;
      bnd = ena && (pos == FRAME - 1);
      segs = 0;
      com  = 0;
      if (ena && !blank) begin
        if (!digit_dark(d))
          segs = tbl[(disp_v >> (4 * d)) & 15] + 128 * ((disp_dp >> d) & 1);
        if (cnt >= DC) com = 1 << d;
      end
      e.seg = seg_pol ? 8'(segs) : ~8'(segs);
      e.com = com_pol ? ND'(com) : ~ND'(com);
      e.oe  = ena ? '1 : '0;
      e.fd  = bnd;
      if (bnd && pend) begin
        disp_v = shd_v; disp_dp = shd_dp; pend = 0;
      end
      if (load) begin
        shd_v = value; shd_dp = dp_mask; pend = 1;
      end
      if (ena) pos = (pos + 1) % FRAME;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit en, input bit ld,
                      input logic [7:0] v, input logic [ND-1:0] dp,
                      input bit bl, input bit sp, input bit cp);
    rst_n = r; ena = en; load = ld; value = v; dp_mask = dp;
    blank = bl; seg_pol = sp; com_pol = cp;
    predict();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [7:0] v, input logic [ND-1:0] dp,
                      input bit sp, input bit cp);
    for (int k = 0; k < n; k++) step(1, 1, 0, v, dp, 0, sp, cp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (seg_out !== e.seg) begin
        errors++;
        $display("FAIL seg_out at %0t: got %02h want %02h", $time, seg_out, e.seg);
      end
      checks++;
      if (com_out !== e.com) begin
        errors++;
        $display("FAIL com_out at %0t: got %b want %b", $time, com_out, e.com);
      end
      checks++;
      if (com_oe !== e.oe) begin
        errors++;
        $display("FAIL com_oe at %0t: got %b want %b", $time, com_oe, e.oe);
      end
      checks++;
      if (frame_done !== e.fd) begin
        errors++;
        $display("FAIL frame_done at %0t: got %b want %b", $time, frame_done, e.fd);
      end
    end
  end

  initial begin
    bit r, en, sp, cp;
    int rst_left;
    rst_n = 0; ena = 0; load = 0; value = 0; dp_mask = 0;
    blank = 0; seg_pol = 1; com_pol = 1;
    predict();
    @(negedge clk);
    #1;
    step(0, 1, 0, 8'h00, 2'b00, 0, 1, 1);
    idle(13, 8'h00, 2'b00, 1, 1);
    step(0, 1, 0, 8'h00, 2'b00, 0, 1, 1);
    step(0, 1, 0, 8'h00, 2'b00, 0, 1, 1);
    step(1, 1, 0, 8'h00, 2'b00, 0, 1, 1);
    step(1, 1, 1, 8'h42, 2'b00, 0, 1, 1);
    idle(24, 8'h00, 2'b00, 1, 1);
    idle(16, 8'h00, 2'b00, 0, 0);
    step(1, 1, 1, 8'h07, 2'b00, 0, 1, 1);
    idle(24, 8'h00, 2'b00, 1, 1);
    step(1, 1, 1, 8'h07, 2'b10, 0, 1, 1);
    idle(20, 8'h00, 2'b00, 1, 1);
    idle(2, 8'h00, 2'b00, 1, 1);
    for (int k = 0; k < 10; k++) step(1, 0, 0, 8'h00, 2'b00, 0, 1, 1);
    idle(12, 8'h00, 2'b00, 1, 1);
    for (int k = 0; k < 20; k++) step(1, 1, 0, 8'h00, 2'b00, 1, 1, 1);
    r = 1; en = 1; sp = 1; cp = 1; rst_left = 0;
    for (int k = 0; k < 1500; k++) begin
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 249) == 0) rst_left = 2;
      r = (rst_left == 0);
      if ($urandom_range(0, 14) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) sp = ~sp;
      if ($urandom_range(0, 49) == 0) cp = ~cp;
      step(r, en, $urandom_range(0, 9) == 0,
           ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom),
           ND'($urandom), $urandom_range(0, 7) == 0, sp, cp);
    end
    idle(4, 8'h00, 2'b00, 1, 1);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 Parameter SCAN_DIV, default 1000, clk cycles per digit slot (legal 4..65535).
REQ-003 Parameter DEAD_CYC, default 2, cycles at the start of each slot with all commons inactive (legal 0..SCAN_DIV-2).
REQ-004 clk  in  1  single clock; all state on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ena  in  1  design enable; low freezes scanning and drives outputs inactive.
REQ-007 load  in  1  one-cycle strobe; captures value and dp_mask.
REQ-008 value  in  4*NUM_DIGITS  hex nibbles; nibble i shown on digit i (digit 0 is least significant).
REQ-009 dp_mask  in  NUM_DIGITS  decimal point per digit.
REQ-010 blank  in  1  forces all segments unlit; scanning continues.
REQ-011 seg_pol  in  1  level driven on a lit segment.
REQ-012 com_pol  in  1  level driven on an active common.
REQ-013 seg_out  out  8  [6:0]=g..a, [7]=dp; registered.
REQ-014 com_out  out  NUM_DIGITS  digit commons; registered.
REQ-015 com_oe  out  NUM_DIGITS  output enables for commons; all ones when ena=1 and out of reset.
REQ-016 frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-017 Prescaler counts 0..SCAN_DIV-1 while ena=1 and holds its value while ena=0; at SCAN_DIV-1 it wraps to 0 and the digit index advances, wrapping from NUM_DIGITS-1 to 0.
REQ-018 Frame boundary is the cycle in which the index wraps to 0; on that edge frame_done=1 for exactly one cycle.
REQ-019 load copies value/dp_mask into a shadow register and sets pending; a second load before the boundary overwrites the shadow.
REQ-020 At a frame boundary with pending=1, the shadow moves to the display register and pending clears; if load and boundary coincide, the new value goes to the shadow and is displayed at the following boundary.
REQ-021 Digit index i selects common i; the common is active only when prescaler >= DEAD_CYC, and all other commons are inactive.
REQ-022 Hex decode uses gfedcba order: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; seg_out[7]=dp_mask[i].
REQ-023 A lit bit drives seg_pol and an unlit bit drives ~seg_pol; an active common drives com_pol and an inactive one drives ~com_pol.
REQ-024 Outputs are registered one cycle after the prescaler/index state that produces them.
REQ-025 When blank=1 or ena=0, all segments are unlit and all commons are inactive on the next edge.
REQ-026 Polarity inputs take effect on the next edge; no glitch suppression is required.

Reset
REQ-027 While rst_n=0: prescaler=0, index=0, display=0, shadow=0, dp=0, pending=0, frame_done=0, seg_out=00, com_out=0, com_oe=0 (commons high-Z).
REQ-028 Reset asserted mid-frame takes effect immediately and discards any pending load; after release, slot 0 begins at prescaler=0.

Configuration
REQ-029 With SEG7_LZB_EN defined, leading-zero blanking applies: digits from NUM_DIGITS-1 downward that are zero, have dp clear, and have only blanked digits above them are shown unlit. Digit 0 is never blanked.
REQ-030 Without SEG7_LZB_EN, every digit is decoded, including leading zeros, and the blanking logic is absent.

Verification (NUM_DIGITS=2, SCAN_DIV=4, DEAD_CYC=1, seg_pol=1, com_pol=1 unless stated)
REQ-031 Assert rst_n=0 mid-scan -> seg_out=00, com_out=00, com_oe=00, frame_done=0; after release with ena=1 -> com_oe=11 and digit 0 shows 3F.
REQ-032 Pulse load with value=8'h42 at prescaler=1 of slot 0 -> digits keep showing 3F until frame_done; afterward slot 0 gives seg_out=5B, com_out=01 and slot 1 gives seg_out=66, com_out=10; frame_done repeats every 8 cycles.
REQ-033 seg_pol=0, com_pol=0, value=8'h42 -> digit 0 seg_out=A4 with com_out=10 (common 0 active low); during the dead cycle com_out=11.
REQ-034 value=8'h07, dp_mask=00: with SEG7_LZB_EN -> digit 1 seg_out=00; without it -> 3F; with dp_mask=10 -> BF in both builds.
REQ-035 ena=0 for 10 cycles mid-slot -> prescaler frozen, seg_out=00, com_out=00; after ena=1, counting resumes from the frozen count.
REQ-036 blank=1 -> seg_out=00, com_out=00 while frame_done keeps pulsing every 8 cycles.
